// File: rtl/data_ram_if.sv
// Request/response bus between the CPU data-memory requester and the RAM responder.
interface data_ram_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_b_en;
  logic [31:0] req_addr;
  logic [31:0] req_w_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_r_data;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_b_en, req_addr, req_w_data, resp_ready,
    input  req_ready, resp_valid, resp_r_data, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_b_en, req_addr, req_w_data, resp_ready,
    output req_ready, resp_valid, resp_r_data, resp_err
  );
endinterface

// File: rtl/data_ram_responder.sv
// Data-memory responder: word-organised RAM with byte enables, programmable
// wait-states and valid/ready handshakes on request and response.
// Optional macro DATA_RAM_FAST_ACCEPT_EN: accept a new request on the same edge
// that retires the current response.
module data_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  data_ram_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [31:0] mem [DEPTH];

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_r_data_q, resp_r_data_d;
  logic                   resp_err_q, resp_err_d;
  logic                   lat_we_q, lat_we_d;
  logic [3:0]             lat_b_en_q, lat_b_en_d;
  logic [ADDR_WIDTH-1:0]  lat_idx_q, lat_idx_d;
  logic [31:0]            lat_w_data_q, lat_w_data_d;
  logic                   lat_oor_q, lat_oor_d;

  logic                   accept;
  logic                   take;
  logic                   use_lat;
  logic                   acc_fire;
  logic                   acc_we;
  logic [3:0]             acc_b_en;
  logic [ADDR_WIDTH-1:0]  acc_idx;
  logic [31:0]            acc_w_data;
  logic                   acc_oor;
  logic                   mem_wr;
  logic [ADDR_WIDTH-1:0]  req_idx;
  logic                   req_oor;
  logic                   unused_addr_lsbs;

  // Decode incoming address: word index and out-of-range flag.
  assign req_idx          = bus.req_addr[ADDR_WIDTH+1:2];
  assign req_oor          = (bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign unused_addr_lsbs = ^bus.req_addr[1:0];

  // Ready is a registered state decode, optionally bypassed by resp_ready in RESP.
`ifdef DATA_RAM_FAST_ACCEPT_EN
  assign bus.req_ready = ready_q | ((state_q == S_RESP) & bus.resp_ready);
`else
  assign bus.req_ready = ready_q;
`endif

  assign accept          = bus.req_valid & bus.req_ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_r_data = resp_r_data_q;
  assign bus.resp_err    = resp_err_q;

  // Next-state, request latching and array access control.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    resp_valid_d  = resp_valid_q;
    resp_r_data_d = resp_r_data_q;
    resp_err_d    = resp_err_q;
    lat_we_d      = lat_we_q;
    lat_b_en_d    = lat_b_en_q;
    lat_idx_d     = lat_idx_q;
    lat_w_data_d  = lat_w_data_q;
    lat_oor_d     = lat_oor_q;
    take          = 1'b0;
    use_lat       = 1'b0;
    acc_fire      = 1'b0;

    case (state_q)
      S_IDLE: take = accept;
      S_WAIT: begin
        if (cnt_q == '0) begin
          acc_fire = 1'b1;
          use_lat  = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
`ifdef DATA_RAM_FAST_ACCEPT_EN
        take = accept;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      lat_we_d     = bus.req_we;
      lat_b_en_d   = bus.req_b_en;
      lat_idx_d    = req_idx;
      lat_w_data_d = bus.req_w_data;
      lat_oor_d    = req_oor;
      if (WAIT_CYCLES != 0) begin
        state_d = S_WAIT;
        cnt_d   = WAIT_LOAD;
      end else begin
        acc_fire = 1'b1;
        state_d  = S_RESP;
      end
    end

    acc_we     = use_lat ? lat_we_q     : bus.req_we;
    acc_b_en   = use_lat ? lat_b_en_q   : bus.req_b_en;
    acc_idx    = use_lat ? lat_idx_q    : req_idx;
    acc_w_data = use_lat ? lat_w_data_q : bus.req_w_data;
    acc_oor    = use_lat ? lat_oor_q    : req_oor;
    mem_wr     = acc_fire & acc_we & ~acc_oor;

    if (acc_fire) begin
      resp_valid_d  = 1'b1;
      resp_err_d    = acc_oor;
      resp_r_data_d = (acc_we | acc_oor) ? 32'd0 : mem[acc_idx];
    end

    ready_d = (state_d == S_IDLE);
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ready_q       <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_r_data_q <= 32'd0;
      resp_err_q    <= 1'b0;
      lat_we_q      <= 1'b0;
      lat_b_en_q    <= 4'd0;
      lat_idx_q     <= '0;
      lat_w_data_q  <= 32'd0;
      lat_oor_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_r_data_q <= resp_r_data_d;
      resp_err_q    <= resp_err_d;
      lat_we_q      <= lat_we_d;
      lat_b_en_q    <= lat_b_en_d;
      lat_idx_q     <= lat_idx_d;
      lat_w_data_q  <= lat_w_data_d;
      lat_oor_q     <= lat_oor_d;
    end
  end

  // Byte-lane RAM write; a reset edge suppresses any pending store.
  always_ff @(posedge clk) begin
    if (reset && mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_b_en[i]) mem[acc_idx][8*i +: 8] <= acc_w_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench: one responder with no wait-states, one with three.
module tb_data_ram_responder;

  logic clk;
  logic rst0;
  logic rst3;
  int   checks;
  int   errors;

  logic [31:0] model0 [1024];
  logic [31:0] model3 [1024];

  data_ram_if if0 ();
  data_ram_if if3 ();

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0), .bus(if0)
  );
  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst3), .bus(if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? if0.req_ready : if3.req_ready;
  endfunction

  function automatic logic get_valid(input int sel);
    return (sel == 0) ? if0.resp_valid : if3.resp_valid;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? if0.resp_r_data : if3.resp_r_data;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? if0.resp_err : if3.resp_err;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] ben);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (ben[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic set_req(input int sel, input logic v, input logic we, input logic [3:0] ben,
                         input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      if0.req_valid = v; if0.req_we = we; if0.req_b_en = ben;
      if0.req_addr = a; if0.req_w_data = d;
    end else begin
      if3.req_valid = v; if3.req_we = we; if3.req_b_en = ben;
      if3.req_addr = a; if3.req_w_data = d;
    end
  endtask

  task automatic set_rr(input int sel, input logic v);
    if (sel == 0) if0.resp_ready = v; else if3.resp_ready = v;
  endtask

  // One transaction: handshake, latency measurement, optional response stall.
  // held=1 means data/err stayed stable and req_ready stayed low until retire.
  task automatic txn(input int sel, input logic we, input logic [3:0] ben,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic err, output int lat,
                     output logic held, output logic to);
    int guard;
    to = 1'b0; held = 1'b1; lat = 0; rd = 32'd0; err = 1'b0;
    @(negedge clk);
    set_req(sel, 1'b1, we, ben, addr, wd);
    guard = 0;
    while (!get_ready(sel) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      set_req(sel, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      to = 1'b1;
      return;
    end
    @(negedge clk);
    set_req(sel, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    lat = 1;
    while (!get_valid(sel) && lat < 40) begin
      if (get_ready(sel)) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!get_valid(sel)) begin
      to = 1'b1;
      return;
    end
    rd  = get_rdata(sel);
    err = get_err(sel);
    for (int h = 0; h < hold; h++) begin
      if (get_ready(sel)) held = 1'b0;
      @(negedge clk);
      if (!get_valid(sel) || get_rdata(sel) !== rd || get_err(sel) !== err) held = 1'b0;
    end
    if (get_ready(sel)) held = 1'b0;
    set_rr(sel, 1'b1);
    @(negedge clk);
    set_rr(sel, 1'b0);
  endtask

  task automatic test_reset();
    set_req(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(3, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_rr(0, 1'b0);
    set_rr(3, 1'b0);
    rst0 = 1'b0; rst3 = 1'b0;
    repeat (3) @(negedge clk);
    rst0 = 1'b1; rst3 = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 4; s += 3) begin
      checks++;
      if (get_valid(s) !== 1'b0 || get_ready(s) !== 1'b1 ||
          get_rdata(s) !== 32'd0 || get_err(s) !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid=%b ready=%b data=%h err=%b expected 0 1 0 0",
                 s, get_valid(s), get_ready(s), get_rdata(s), get_err(s));
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic err; int lat; logic held; logic to;
    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, rd, err, lat, held, to);
    model0[4] = 32'hDEADBEEF;
    checks++;
    if (to || rd !== 32'd0 || err !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL store_resp: to=%b data=%h err=%b lat=%0d expected 0 00000000 0 1", to, rd, err, lat);
    end
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 0, rd, err, lat, held, to);
    checks++;
    if (to || rd !== 32'hDEADBEEF || err !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL load_after_store: to=%b data=%h err=%b lat=%0d expected 0 deadbeef 0 1", to, rd, err, lat);
    end
    txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 0, rd, err, lat, held, to);
    txn(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 0, rd, err, lat, held, to);
    model0[8] = 32'h11BB33DD;
    checks++;
    if (to || rd !== 32'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL partial_store_resp: to=%b data=%h err=%b expected 0 00000000 0", to, rd, err);
    end
    txn(0, 1'b0, 4'h0, 32'h22, 32'h0, 0, rd, err, lat, held, to);
    checks++;
    if (to || rd !== 32'h11BB33DD || err !== 1'b0) begin
      errors++;
      $display("FAIL byte_enable_merge: to=%b data=%h expected 11bb33dd", to, rd);
    end
  endtask

  task automatic test_wait_stall();
    logic [31:0] rd; logic err; int lat; logic held; logic to;
    txn(3, 1'b1, 4'hF, 32'h10, 32'hCAFEF00D, 0, rd, err, lat, held, to);
    model3[4] = 32'hCAFEF00D;
    checks++;
    if (to || rd !== 32'd0 || lat != 4) begin
      errors++;
      $display("FAIL wait_store: to=%b data=%h lat=%0d expected 0 00000000 4", to, rd, lat);
    end
    txn(3, 1'b0, 4'h0, 32'h10, 32'h0, 5, rd, err, lat, held, to);
    checks++;
    if (to || lat != 4) begin
      errors++;
      $display("FAIL wait_latency: to=%b lat=%0d expected 0 4", to, lat);
    end
    checks++;
    if (rd !== 32'hCAFEF00D || err !== 1'b0 || held !== 1'b1) begin
      errors++;
      $display("FAIL wait_stall_hold: data=%h err=%b held=%b expected cafef00d 0 1", rd, err, held);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int lat; logic held; logic to;
    txn(0, 1'b1, 4'hF, 32'h0, 32'h01234567, 0, rd, err, lat, held, to);
    model0[0] = 32'h01234567;
    txn(0, 1'b0, 4'h0, 32'h0001_0000, 32'h0, 0, rd, err, lat, held, to);
    checks++;
    if (to || rd !== 32'd0 || err !== 1'b1) begin
      errors++;
      $display("FAIL oor_load: to=%b data=%h err=%b expected 0 00000000 1", to, rd, err);
    end
    txn(0, 1'b1, 4'hF, 32'h0001_0000, 32'hFFFFFFFF, 0, rd, err, lat, held, to);
    checks++;
    if (to || rd !== 32'd0 || err !== 1'b1) begin
      errors++;
      $display("FAIL oor_store: to=%b data=%h err=%b expected 0 00000000 1", to, rd, err);
    end
    txn(0, 1'b0, 4'h0, 32'h0, 32'h0, 0, rd, err, lat, held, to);
    checks++;
    if (to || rd !== 32'h01234567 || err !== 1'b0) begin
      errors++;
      $display("FAIL oor_no_write: data=%h err=%b expected 01234567 0", rd, err);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic err; int lat; logic held; logic to;
    int guard;
    txn(3, 1'b1, 4'hF, 32'h40, 32'h5A5A1234, 0, rd, err, lat, held, to);
    model3[16] = 32'h5A5A1234;
    @(negedge clk);
    set_req(3, 1'b1, 1'b1, 4'hF, 32'h40, 32'h0BAD0BAD);
    guard = 0;
    while (!if3.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    set_req(3, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    rst3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    checks++;
    if (if3.resp_valid !== 1'b0 || if3.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_wait: valid=%b ready=%b expected 0 1", if3.resp_valid, if3.req_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (if3.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_resp: valid=%b expected 0", if3.resp_valid);
    end
    txn(3, 1'b0, 4'h0, 32'h40, 32'h0, 0, rd, err, lat, held, to);
    checks++;
    if (to || rd !== 32'h5A5A1234) begin
      errors++;
      $display("FAIL reset_store_dropped: data=%h expected 5a5a1234", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic err; int lat; logic held; logic to;
    logic [31:0] exp_d; logic exp_e;
    logic [31:0] addr, wd;
    logic [3:0]  ben;
    logic        we, oor;
    int          idx;
    for (int s = 0; s < 4; s += 3) begin
      for (int k = 0; k < 8; k++) begin
        wd = $urandom;
        txn(s, 1'b1, 4'hF, 32'((100 + k) * 4), wd, 0, rd, err, lat, held, to);
        if (s == 0) model0[100 + k] = wd; else model3[100 + k] = wd;
      end
      for (int n = 0; n < 30; n++) begin
        idx  = 100 + int'($urandom_range(0, 7));
        we   = 1'($urandom_range(0, 1));
        ben  = 4'($urandom_range(0, 15));
        wd   = $urandom;
        oor  = ($urandom_range(0, 5) == 0);
        addr = 32'(idx * 4) | 32'($urandom_range(0, 3));
        if (oor) addr = addr | {20'($urandom_range(1, 20'hFFFFF)), 12'h0};
        exp_e = oor;
        if (oor || we) exp_d = 32'd0;
        else exp_d = (s == 0) ? model0[idx] : model3[idx];
        if (!oor && we) begin
          if (s == 0) model0[idx] = merge(model0[idx], wd, ben);
          else model3[idx] = merge(model3[idx], wd, ben);
        end
        txn(s, we, ben, addr, wd, int'($urandom_range(0, 2)), rd, err, lat, held, to);
        checks++;
        if (to || rd !== exp_d || err !== exp_e || lat != ((s == 0) ? 1 : 4) || !held) begin
          errors++;
          $display("FAIL random dut%0d #%0d: to=%b data=%h err=%b lat=%0d held=%b expected data=%h err=%b",
                   s, n, to, rd, err, lat, held, exp_d, exp_e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat; logic held; logic to;
    int cyc, got, sent, gap;
    logic pend;
    int rc [4];
    logic [31:0] rdat [4];
    for (int k = 0; k < 4; k++) begin
      txn(0, 1'b1, 4'hF, 32'(32'h80 + k * 4), 32'hB0B0_0000 + 32'(k), 0, rd, err, lat, held, to);
      model0[32 + k] = 32'hB0B0_0000 + 32'(k);
    end
`ifdef DATA_RAM_FAST_ACCEPT_EN
    gap = 1;
`else
    gap = 2;
`endif
    @(negedge clk);
    if0.resp_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'd0, 32'h80, 32'd0);
    pend = if0.req_ready;
    cyc = 0; got = 0; sent = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (if0.resp_valid) begin
        rc[got] = cyc;
        rdat[got] = if0.resp_r_data;
        got++;
      end
      if (pend) begin
        sent++;
        if (sent < 4) if0.req_addr = 32'(32'h80 + sent * 4);
        else if0.req_valid = 1'b0;
      end
      pend = if0.req_valid && if0.req_ready;
    end
    if0.req_valid = 1'b0;
    @(negedge clk);
    if0.resp_ready = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses expected 4", got);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rdat[k] !== model0[32 + k] || (k > 0 && rc[k] - rc[k-1] != gap)) begin
          errors++;
          $display("FAIL b2b_resp%0d: data=%h spacing=%0d expected data=%h spacing=%0d",
                   k, rdat[k], (k > 0) ? rc[k] - rc[k-1] : gap, model0[32 + k], gap);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst0 = 1'b0;
    rst3 = 1'b0;
    test_reset();
    test_store_load();
    test_wait_stall();
    test_out_of_range();
    test_reset_in_wait();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder (slave) end of the CPU data-memory interface. Takes load/store requests from the EXE-side address/control logic and returns read data to the MEM stage, which forwards it unaligned to WB.
- Holds a word-organised synchronous RAM with per-byte write enables.
- Supports a configurable number of wait-states and a valid/ready handshake on both request and response, so the pipeline can stall on memory.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; the RAM holds 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 0, extra cycles between request acceptance and array access (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_b_en  in  4  byte enables for stores; bit i covers bits [8i+7:8i]. Ignored for loads.
- req_addr  in  32  byte address; bits [1:0] are ignored.
- req_w_data  in  32  store data, already lane-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response this cycle.
- resp_r_data  out  32  full read word. 0 for stores and errors.
- resp_err  out  1  address was out of range.

Behaviour:
- Reset (reset==0 at a clock edge) forces:
  - state=IDLE, resp_valid=0, resp_r_data=0, resp_err=0, wait counter=0.
  - RAM contents are not cleared.
  - A request in WAIT is dropped, including any store, which does not write.
  - A pending response is discarded.
- Word index = req_addr[ADDR_WIDTH+1:2]. The request is out of range iff req_addr[31:ADDR_WIDTH+2] != 0.
- A request is accepted on an edge where req_valid & req_ready. At acceptance, we, b_en, index, w_data and the out-of-range flag are latched.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On accept: go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to RESP and perform the access on that same edge.
  - WAIT: req_ready=0. Counter decrements each cycle. When the counter is 0, the access is performed on that edge and the state goes to RESP.
  - RESP: resp_valid=1. resp_r_data and resp_err are held stable until resp_ready. On resp_valid & resp_ready the state goes to IDLE (subject to the Optional Feature).
- Access rules:
  - Load in range: resp_r_data = RAM[index].
  - Store in range: for each i with b_en[i]=1, RAM[index] byte i = w_data byte i; resp_r_data=0. b_en=0000 is a legal no-op that still responds.
  - Out of range: no write, resp_r_data=0, resp_err=1.
- Latency: acceptance edge to first cycle of resp_valid is WAIT_CYCLES+1 cycles.
- Ordering:
  - Exactly one response per accepted request, in order.
  - At most one transaction is outstanding.
  - A load that follows a store to the same word returns the post-store value.
- Outputs are registered. req_ready depends only on state, plus resp_ready under the feature.
- Without the feature, resp_ready asserted outside RESP has no effect.

Optional Feature:
- Macro: DATA_RAM_FAST_ACCEPT_EN.
- With it defined:
  - In RESP, req_ready = resp_ready.
  - On an edge with resp_valid & resp_ready & req_valid, the old response retires and the new request is accepted on the same edge.
  - Next state: RESP with the new result if WAIT_CYCLES==0, else WAIT.
  - With WAIT_CYCLES=0 this gives one transaction per cycle.
- Without it: req_ready=1 only in IDLE, so the minimum is 2 cycles per transaction.

Test Plan:
- WAIT_CYCLES=0, store addr 0x10, b_en 1111, data 0xDEADBEEF, then load 0x10 -> load response 0xDEADBEEF, resp_err=0, resp_valid exactly 1 cycle after accept.
- Store 0x11223344 to 0x20 (b_en 1111), then store 0xAABBCCDD with b_en 0101, then load 0x20 -> 0x11BB33DD. The store response resp_r_data is 0.
- WAIT_CYCLES=3, load 0x10 with resp_ready held 0 for 5 cycles:
  - resp_valid rises 4 cycles after accept.
  - resp_r_data is stable across the stall.
  - req_ready=0 throughout (feature off).
- Load 0x0001_0000 with ADDR_WIDTH=10 -> resp_err=1, resp_r_data=0. A store to the same address leaves RAM word 0 unchanged.
- Store in WAIT state, reset driven 0 for 1 cycle -> resp_valid=0, req_ready=1 the next cycle, target word unchanged on a subsequent load.
- DATA_RAM_FAST_ACCEPT_EN, WAIT_CYCLES=0, 4 back-to-back loads with resp_ready=1 -> 4 responses on 4 consecutive cycles, in order. Without the macro -> responses every 2 cycles.
